if_fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer that owns the program counter. It issues one request at a time to the instruction memory over a req/ack handshake and buffers the returned word in a one-entry output slot for decode.
- It handles decode stalls and execute-stage branch redirects, including a redirect that arrives while a memory request is still outstanding.
- It sits between the execute stage (branch inputs), the instruction memory, and the IF/ID boundary.

---
 rtl/if_fetch_ctrl_pkg.sv | 21 ++
 rtl/if_fetch_ctrl.sv | 133 +++++++++++++
 tb/tb_if_fetch_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared fetch definitions: FSM state codes, bus widths and the default reset PC.
package if_fetch_ctrl_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic [INST_ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_RST   = 2'd0,
    FETCH_IDLE  = 2'd1,
    FETCH_BUSY  = 2'd2,
    FETCH_DRAIN = 2'd3
  } fetch_state_e;

  // Sequential fetch step; wraps naturally modulo 2^32.
  function automatic logic [INST_ADDR_W-1:0] seq_pc(input logic [INST_ADDR_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs one imem req/ack handshake at a
// time and holds the returned word in a one-entry slot for decode.
//
// state | meaning
// RST   | dead cycle after reset, no request
// IDLE  | no request outstanding; issue when the slot is free
// BUSY  | request outstanding for the current fetch
// DRAIN | request outstanding for a fetch squashed by a redirect
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   branch_flag_i,
  input  logic [INST_ADDR_W-1:0] branch_target_address_i,
  input  logic                   stall_i,
  output logic                   imem_req_o,
  output logic [INST_ADDR_W-1:0] imem_addr_o,
  input  logic                   imem_ack_i,
  input  logic [INST_W-1:0]      imem_data_i,
  output logic                   inst_valid_o,
  output logic [INST_W-1:0]      inst_o,
  output logic [INST_ADDR_W-1:0] inst_pc_o,
  output logic [INST_ADDR_W-1:0] pc_o
);

  fetch_state_e           state_q, state_d;
  logic                   req_q, req_d;
  logic [INST_ADDR_W-1:0] addr_q, addr_d;
  logic                   valid_q, valid_d;
  logic [INST_W-1:0]      inst_q, inst_d;
  logic [INST_ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [INST_ADDR_W-1:0] pc_q, pc_d;

  logic consume;
  logic slot_free;

  assign consume   = valid_q & ~stall_i;
  assign slot_free = ~valid_q | consume;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH_RST;
      req_q     <= 1'b0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      pc_q      <= RESET_PC;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      pc_q      <= pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    valid_d   = valid_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    pc_d      = pc_q;

    // A redirect flushes the younger buffered instruction in every state.
    if (consume || branch_flag_i) begin
      valid_d = 1'b0;
    end

    case (state_q)
      FETCH_RST: begin
        req_d   = 1'b0;
        state_d = FETCH_IDLE;
      end
      FETCH_IDLE: begin
        req_d = 1'b0;
        if (branch_flag_i) begin
          pc_d = branch_target_address_i;
        end else if (slot_free) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = FETCH_BUSY;
        end
      end
      FETCH_BUSY: begin
        if (imem_ack_i) begin
          req_d   = 1'b0;
          state_d = FETCH_IDLE;
          if (branch_flag_i) begin
            pc_d = branch_target_address_i;
          end else begin
            inst_d    = imem_data_i;
            inst_pc_d = addr_q;
            valid_d   = 1'b1;
            pc_d      = seq_pc(pc_q);
          end
        end else if (branch_flag_i) begin
          // The handshake cannot be abandoned; finish it on the stale address.
          pc_d    = branch_target_address_i;
          state_d = FETCH_DRAIN;
        end
      end
      FETCH_DRAIN: begin
        if (branch_flag_i) begin
          pc_d = branch_target_address_i;
        end
        if (imem_ack_i) begin
          req_d   = 1'b0;
          state_d = FETCH_IDLE;
        end
      end
      default: begin
        state_d = FETCH_RST;
        req_d   = 1'b0;
      end
    endcase
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = addr_q;
  assign inst_valid_o = valid_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign pc_o         = pc_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: a memory responder with programmable ack delay, and a
// scoreboard monitor that checks each new request and each consumed instruction.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        stall_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic [31:0] pc_o;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_delay = 0;
  int resp_cnt  = 0;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_ipc[$];
  logic [31:0] exp_inst[$];
  logic        prev_req = 1'b0;
  logic [31:0] mon_a;
  logic [31:0] mon_d;

  if_fetch_ctrl dut (
    .clk                     (clk),
    .rst                     (rst),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .stall_i                 (stall_i),
    .imem_req_o              (imem_req_o),
    .imem_addr_o             (imem_addr_o),
    .imem_ack_i              (imem_ack_i),
    .imem_data_i             (imem_data_i),
    .inst_valid_o            (inst_valid_o),
    .inst_o                  (inst_o),
    .inst_pc_o               (inst_pc_o),
    .pc_o                    (pc_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_req(input logic [31:0] a);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req_o && imem_addr_o == a) begin
        n_checks++;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_req timeout: got req=%b addr=%h expected addr=%h", imem_req_o, imem_addr_o, a);
  endtask

  task automatic wait_valid(input logic [31:0] a);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (inst_valid_o && inst_pc_o == a) begin
        n_checks++;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_valid timeout: got valid=%b inst_pc=%h expected inst_pc=%h", inst_valid_o, inst_pc_o, a);
  endtask

  // Memory responder: acks after ack_delay extra cycles of req, one-cycle pulse.
  initial begin
    imem_ack_i  = 1'b0;
    imem_data_i = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        imem_ack_i = 1'b0;
        resp_cnt   = 0;
      end else if (imem_ack_i) begin
        imem_ack_i = 1'b0;
        resp_cnt   = 0;
      end else if (imem_req_o) begin
        if (resp_cnt >= ack_delay) begin
          imem_ack_i  = 1'b1;
          imem_data_i = mem_word(imem_addr_o);
        end else begin
          resp_cnt++;
        end
      end else begin
        resp_cnt = 0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (imem_req_o && !prev_req) begin
        if (exp_addr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_req: got addr=%h expected no request", imem_addr_o);
        end else begin
          mon_a = exp_addr.pop_front();
          check("req_addr", imem_addr_o, mon_a);
        end
      end
      prev_req = imem_req_o;
      if (inst_valid_o && !stall_i) begin
        if (exp_ipc.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_inst: got inst_pc=%h expected no instruction", inst_pc_o);
        end else begin
          mon_a = exp_ipc.pop_front();
          mon_d = exp_inst.pop_front();
          check("inst_pc", inst_pc_o, mon_a);
          check("inst", inst_o, mon_d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog");
  end

  task automatic reset_checks(input string tag);
    check({tag, "_req"}, {31'h0, imem_req_o}, 32'h0);
    check({tag, "_valid"}, {31'h0, inst_valid_o}, 32'h0);
    check({tag, "_pc"}, pc_o, 32'h0);
    check({tag, "_inst"}, inst_o, 32'h0);
    check({tag, "_inst_pc"}, inst_pc_o, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    branch_flag_i = 1'b0;
    branch_target_address_i = 32'h0;
    stall_i = 1'b0;
    ack_delay = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_checks("reset");
    check("reset_addr", imem_addr_o, 32'h0);
    rst = 1'b0;

    // Back-to-back fetches with immediate ack, then a 5-cycle decode stall.
    exp_addr.push_back(32'h0);  exp_addr.push_back(32'h4);
    exp_addr.push_back(32'h8);  exp_addr.push_back(32'hC);
    exp_ipc.push_back(32'h0); exp_inst.push_back(32'hDEAD_0000);
    exp_ipc.push_back(32'h4); exp_inst.push_back(32'hDEAD_0004);
    exp_ipc.push_back(32'h8); exp_inst.push_back(32'hDEAD_0008);
    exp_ipc.push_back(32'hC); exp_inst.push_back(32'hDEAD_000C);
    @(negedge clk); check("c1_req", {31'h0, imem_req_o}, 32'h0);
    @(negedge clk); check("c2_req", {31'h0, imem_req_o}, 32'h1); check("c2_addr", imem_addr_o, 32'h0);
    @(negedge clk); check("c3_req", {31'h0, imem_req_o}, 32'h0); check("c3_valid", {31'h0, inst_valid_o}, 32'h1);
    @(negedge clk); check("c4_req", {31'h0, imem_req_o}, 32'h1); check("c4_addr", imem_addr_o, 32'h4);
    @(negedge clk); check("c5_req", {31'h0, imem_req_o}, 32'h0);
    @(negedge clk); check("c6_req", {31'h0, imem_req_o}, 32'h1); check("c6_addr", imem_addr_o, 32'h8);
    @(posedge clk); #1 stall_i = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_req", {31'h0, imem_req_o}, 32'h0);
      check("stall_valid", {31'h0, inst_valid_o}, 32'h1);
      check("stall_inst", inst_o, 32'hDEAD_0008);
    end
    @(posedge clk); #1 stall_i = 1'b0;
    @(negedge clk); check("release_req0", {31'h0, imem_req_o}, 32'h0);
    @(negedge clk); check("release_req1", {31'h0, imem_req_o}, 32'h1); check("release_addr", imem_addr_o, 32'hC);
    ack_delay = 3;

    // Redirect while BUSY with the ack held off: drain on the stale address.
    exp_addr.push_back(32'h10); exp_addr.push_back(32'h100);
    exp_ipc.push_back(32'h100); exp_inst.push_back(32'hDEAD_0100);
    wait_req(32'h10);
    branch_flag_i = 1'b1; branch_target_address_i = 32'h100;
    @(posedge clk); #1 branch_flag_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("drain_req", {31'h0, imem_req_o}, 32'h1);
      check("drain_addr", imem_addr_o, 32'h10);
      check("drain_valid", {31'h0, inst_valid_o}, 32'h0);
      check("drain_pc", pc_o, 32'h100);
    end
    @(negedge clk); check("post_drain_req", {31'h0, imem_req_o}, 32'h0); check("post_drain_valid", {31'h0, inst_valid_o}, 32'h0);
    wait_req(32'h100);
    ack_delay = 0;

    // Redirect coincident with ack: data discarded, no slot write.
    exp_addr.push_back(32'h104); exp_addr.push_back(32'h180);
    wait_req(32'h104);
    branch_flag_i = 1'b1; branch_target_address_i = 32'h180;
    @(posedge clk); #1 branch_flag_i = 1'b0;
    @(negedge clk);
    check("coinc_valid", {31'h0, inst_valid_o}, 32'h0);
    check("coinc_req", {31'h0, imem_req_o}, 32'h0);
    check("coinc_pc", pc_o, 32'h180);
    ack_delay = 4;

    // Redirects back to back: first enters DRAIN, the next two land in DRAIN.
    exp_addr.push_back(32'h300);
    wait_req(32'h180);
    branch_flag_i = 1'b1; branch_target_address_i = 32'h1F0;
    @(posedge clk); #1 branch_target_address_i = 32'h200;
    @(negedge clk); check("d1_pc", pc_o, 32'h1F0); check("d1_addr", imem_addr_o, 32'h180);
    @(posedge clk); #1 branch_target_address_i = 32'h300;
    @(negedge clk); check("d2_pc", pc_o, 32'h200);
    @(posedge clk); #1 branch_flag_i = 1'b0;
    @(negedge clk); check("d3_pc", pc_o, 32'h300); check("d3_req", {31'h0, imem_req_o}, 32'h1);
    check("d3_addr", imem_addr_o, 32'h180);
    wait_req(32'h300);
    ack_delay = 0;

    // Redirect from IDLE to the top word, PC wrap, then reset mid-BUSY.
    exp_ipc.push_back(32'h300); exp_inst.push_back(32'hDEAD_0300);
    exp_addr.push_back(32'hFFFF_FFFC);
    exp_ipc.push_back(32'hFFFF_FFFC); exp_inst.push_back(32'h2152_FFFC);
    exp_addr.push_back(32'h0); exp_addr.push_back(32'h0);
    wait_valid(32'h300);
    branch_flag_i = 1'b1; branch_target_address_i = 32'hFFFF_FFFC;
    @(posedge clk); #1 branch_flag_i = 1'b0;
    @(negedge clk);
    check("idle_br_req", {31'h0, imem_req_o}, 32'h0);
    check("idle_br_pc", pc_o, 32'hFFFF_FFFC);
    check("idle_br_valid", {31'h0, inst_valid_o}, 32'h0);
    @(negedge clk); check("top_req", {31'h0, imem_req_o}, 32'h1); check("top_addr", imem_addr_o, 32'hFFFF_FFFC);
    @(negedge clk); check("wrap_valid", {31'h0, inst_valid_o}, 32'h1); check("wrap_pc", pc_o, 32'h0);
    ack_delay = 3;
    @(negedge clk); check("busy_req", {31'h0, imem_req_o}, 32'h1); check("busy_addr", imem_addr_o, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    reset_checks("midrst");
    rst = 1'b0;
    ack_delay = 0;
    @(negedge clk); check("restart_c1_req", {31'h0, imem_req_o}, 32'h0);
    @(negedge clk); check("restart_req", {31'h0, imem_req_o}, 32'h1); check("restart_addr", imem_addr_o, 32'h0);
    @(posedge clk); #1 stall_i = 1'b1;
    @(negedge clk);
    check("restart_valid", {31'h0, inst_valid_o}, 32'h1);
    check("restart_inst_pc", inst_pc_o, 32'h0);
    check("restart_inst", inst_o, 32'hDEAD_0000);
    @(negedge clk); check("final_req", {31'h0, imem_req_o}, 32'h0);

    check("addr_queue_left", exp_addr.size(), 32'h0);
    check("inst_queue_left", exp_ipc.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
